// File: rtl/divider_rate_ctrl.sv
// divider_rate_ctrl
// Converts one-cycle speed commands into a saturated divisor for the
// programmable clock divider. A new divisor is staged and only committed
// on a divider output toggle, so every half-period of clk_out uses exactly
// one divisor. A stalled divider is handled by a timeout-forced commit.
module divider_rate_ctrl #(
    parameter int N         = 25,
    parameter int DEFAULT_N = 568,
    parameter int STEP      = 8,
    parameter int MIN_N     = 64,
    parameter int MAX_N     = 4096
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         speed_up,
    input  logic         speed_down,
    input  logic         speed_default,
    input  logic         div_clk,
    output logic [N-1:0] n_out,
    output logic         busy,
    output logic         commit_pulse,
    output logic         at_min,
    output logic         at_max,
    output logic         timeout_err
);

    // One extra bit so step arithmetic can never wrap silently.
    localparam int NW = N + 1;

    localparam logic [NW-1:0] C_DEFAULT  = NW'(DEFAULT_N);
    localparam logic [NW-1:0] C_STEP     = NW'(STEP);
    localparam logic [NW-1:0] C_MIN      = NW'(MIN_N);
    localparam logic [NW-1:0] C_MAX      = NW'(MAX_N);
    localparam logic [NW-1:0] C_UP_FLOOR = C_MIN + C_STEP;
    localparam logic [NW-1:0] C_ONE      = NW'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_n;
    logic [N-1:0]    r_staged;
    logic [NW-1:0]   r_cnt;
    logic            r_div_prev;
    logic            r_busy;
    logic            r_commit;
    logic            r_at_min;
    logic            r_at_max;
    logic            r_timeout_err;

    logic [NW-1:0]   w_n_ext;
    logic [NW-1:0]   w_up;
    logic [NW-1:0]   w_down_sum;
    logic [NW-1:0]   w_down;
    logic [NW-1:0]   w_result;
    logic            w_cmd;
    logic            w_accept;
    logic            w_toggle;
    logic            w_timeout;

    assign w_n_ext   = {1'b0, r_n};
    assign w_toggle  = div_clk ^ r_div_prev;
    // The counter starts at 0 in the first busy cycle, so reaching n_out
    // here means n_out + 1 busy cycles have elapsed at the next edge.
    assign w_timeout = (r_cnt == w_n_ext);
    assign w_cmd     = speed_default | speed_up | speed_down;
    assign w_accept  = w_cmd & (w_result != w_n_ext);

    // Saturated step results and command selection (default > up > down).
    always_comb begin
        w_up       = C_MIN;
        w_down_sum = w_n_ext + C_STEP;
        w_down     = C_MAX;
        w_result   = w_n_ext;

        if (w_n_ext < C_UP_FLOOR) begin
            w_up = C_MIN;
        end else begin
            w_up = w_n_ext - C_STEP;
        end

        if (w_down_sum > C_MAX) begin
            w_down = C_MAX;
        end else begin
            w_down = w_down_sum;
        end

        if (speed_default) begin
            w_result = C_DEFAULT;
        end else if (speed_up) begin
            w_result = w_up;
        end else if (speed_down) begin
            w_result = w_down;
        end else begin
            w_result = w_n_ext;
        end
    end

    // Control FSM: stage in IDLE, commit on toggle or timeout in PENDING.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_n           <= C_DEFAULT[N-1:0];
            r_staged      <= {N{1'b0}};
            r_cnt         <= {NW{1'b0}};
            r_div_prev    <= 1'b0;
            r_busy        <= 1'b0;
            r_commit      <= 1'b0;
            r_at_min      <= (C_DEFAULT == C_MIN);
            r_at_max      <= (C_DEFAULT == C_MAX);
            r_timeout_err <= 1'b0;
        end else begin
            r_div_prev <= div_clk;
            r_commit   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_staged <= w_result[N-1:0];
                        r_cnt    <= {NW{1'b0}};
                        r_busy   <= 1'b1;
                        r_state  <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (w_toggle || w_timeout) begin
                        r_n      <= r_staged;
                        r_at_min <= ({1'b0, r_staged} == C_MIN);
                        r_at_max <= ({1'b0, r_staged} == C_MAX);
                        r_commit <= 1'b1;
                        r_busy   <= 1'b0;
                        r_cnt    <= {NW{1'b0}};
                        r_state  <= ST_IDLE;
                        // A real toggle in the same cycle makes this a normal commit.
                        if (!w_toggle) begin
                            r_timeout_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= {NW{1'b0}};
                end
            endcase
        end
    end

    assign n_out        = r_n;
    assign busy         = r_busy;
    assign commit_pulse = r_commit;
    assign at_min       = r_at_min;
    assign at_max       = r_at_max;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_divider_rate_ctrl.sv
// Testbench for divider_rate_ctrl: an event-level reference model checked
// against the DUT every cycle, plus directed scenarios with literal checks.
module tb_divider_rate_ctrl;

    localparam int P_DEF  = 10;
    localparam int P_STEP = 4;
    localparam int P_MIN  = 4;
    localparam int P_MAX  = 20;

    logic       clk_in        = 1'b0;
    logic       reset         = 1'b1;
    logic       speed_up      = 1'b0;
    logic       speed_down    = 1'b0;
    logic       speed_default = 1'b0;
    logic       div_clk       = 1'b0;
    logic [7:0] n_out;
    logic       busy;
    logic       commit_pulse;
    logic       at_min;
    logic       at_max;
    logic       timeout_err;

    int n_vec  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    // Divider emulation: div_clk flips every div_half cycles while running.
    bit div_run  = 1'b0;
    int div_half = 10;
    int div_cnt  = 0;

    // Reference model state.
    int m_n      = P_DEF;
    int m_staged = 0;
    int m_age    = 0;
    bit m_busy   = 1'b0;
    bit m_commit = 1'b0;
    bit m_err    = 1'b0;
    bit m_prev   = 1'b0;

    divider_rate_ctrl #(
        .N(8), .DEFAULT_N(P_DEF), .STEP(P_STEP), .MIN_N(P_MIN), .MAX_N(P_MAX)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .speed_up     (speed_up),
        .speed_down   (speed_down),
        .speed_default(speed_default),
        .div_clk      (div_clk),
        .n_out        (n_out),
        .busy         (busy),
        .commit_pulse (commit_pulse),
        .at_min       (at_min),
        .at_max       (at_max),
        .timeout_err  (timeout_err)
    );

    // Clock generation.
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Divider output emulation, driven away from the sampling edge.
    always @(negedge clk_in) begin
        if (div_run) begin
            div_cnt++;
            if (div_cnt >= div_half) begin
                div_cnt = 0;
                div_clk = ~div_clk;
            end
        end
    end

    // Reference model: a request waits until the divider output changes
    // or until n+1 busy cycles have passed, then the target takes effect.
    always @(posedge clk_in) begin
        bit tog;
        int tgt;
        tog      = (div_clk != m_prev);
        m_prev   = div_clk;
        m_commit = 1'b0;
        tgt      = m_n;
        if (reset) begin
            m_n    = P_DEF;
            m_busy = 1'b0;
            m_err  = 1'b0;
            m_prev = 1'b0;
            m_age  = 0;
        end else if (m_busy) begin
            m_age++;
            if (tog || (m_age == m_n + 1)) begin
                if (!tog) m_err = 1'b1;
                m_n      = m_staged;
                m_busy   = 1'b0;
                m_commit = 1'b1;
            end
        end else if (speed_default || speed_up || speed_down) begin
            if (speed_default)   tgt = P_DEF;
            else if (speed_up)   tgt = (m_n - P_STEP < P_MIN) ? P_MIN : m_n - P_STEP;
            else                 tgt = (m_n + P_STEP > P_MAX) ? P_MAX : m_n + P_STEP;
            if (tgt != m_n) begin
                m_staged = tgt;
                m_busy   = 1'b1;
                m_age    = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("n_out",        int'(n_out),        m_n);
            chk("busy",         int'(busy),         int'(m_busy));
            chk("commit_pulse", int'(commit_pulse), int'(m_commit));
            chk("at_min",       int'(at_min),       int'(m_n == P_MIN));
            chk("at_max",       int'(at_max),       int'(m_n == P_MAX));
            chk("timeout_err",  int'(timeout_err),  int'(m_err));
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk_in);
    endtask

    // Present one command for exactly one cycle.
    task automatic cmd(input bit u, input bit d, input bit f);
        speed_up      = u;
        speed_down    = d;
        speed_default = f;
        @(negedge clk_in);
        speed_up      = 1'b0;
        speed_down    = 1'b0;
        speed_default = 1'b0;
    endtask

    // Bounded wait for commit_pulse; returns the number of cycles waited.
    task automatic wait_commit(output int cycles, input int budget);
        cycles = 0;
        while (!commit_pulse && cycles < budget) begin
            @(negedge clk_in);
            cycles++;
        end
        chk("commit_seen", int'(commit_pulse), 1);
    endtask

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed scenarios.
    initial begin
        int c;
        int exp_dn [3] = '{14, 18, 20};

        // 1: reset and idle with a frozen divider.
        reset = 1'b1;
        tick(2);
        chk_en = 1'b1;
        chk("rst_n_out",  int'(n_out), 10);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_at_min", int'(at_min), 0);
        chk("rst_at_max", int'(at_max), 0);
        chk("rst_err",    int'(timeout_err), 0);
        reset = 1'b0;
        c = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (commit_pulse) c++;
        end
        chk("idle_commits", c, 0);

        // 2: one speed_up with the divider toggling every 10 cycles.
        div_half = 10;
        div_run  = 1'b1;
        tick(3);
        cmd(1'b1, 1'b0, 1'b0);
        chk("t2_busy", int'(busy), 1);
        wait_commit(c, 40);
        chk("t2_n_out", int'(n_out), 6);
        chk("t2_busy_clr", int'(busy), 0);

        // 3: down to MIN, then a saturated speed_up is a no-op.
        div_half = 3;
        tick(2);
        cmd(1'b1, 1'b0, 1'b0);
        wait_commit(c, 40);
        chk("t3_n_out", int'(n_out), 4);
        chk("t3_at_min", int'(at_min), 1);
        tick(2);
        cmd(1'b1, 1'b0, 1'b0);
        chk("t3_sat_busy", int'(busy), 0);
        tick(6);
        chk("t3_sat_n", int'(n_out), 4);

        // 4: from default, five speed_down then restore.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t4_rst_n", int'(n_out), 10);
        for (int i = 0; i < 3; i++) begin
            tick(2);
            cmd(1'b0, 1'b1, 1'b0);
            wait_commit(c, 40);
            chk("t4_down_n", int'(n_out), exp_dn[i]);
        end
        for (int i = 0; i < 2; i++) begin
            tick(2);
            cmd(1'b0, 1'b1, 1'b0);
            chk("t4_sat_busy", int'(busy), 0);
        end
        tick(4);
        chk("t4_at_max", int'(at_max), 1);
        cmd(1'b0, 1'b0, 1'b1);
        wait_commit(c, 40);
        chk("t4_default_n", int'(n_out), 10);

        // 5: command while busy is dropped; up beats down; commit-cycle accept.
        tick(2);
        cmd(1'b0, 1'b1, 1'b0);
        chk("t5_busy", int'(busy), 1);
        cmd(1'b1, 1'b0, 1'b0);
        wait_commit(c, 40);
        chk("t5_n_out", int'(n_out), 14);
        tick(1);
        chk("t5_dropped", int'(busy), 0);
        cmd(1'b0, 1'b0, 1'b1);
        wait_commit(c, 40);
        chk("t5_default_n", int'(n_out), 10);
        cmd(1'b1, 1'b1, 1'b0);
        chk("t5_commit_accept", int'(busy), 1);
        wait_commit(c, 40);
        chk("t5_updown_n", int'(n_out), 6);

        // 6: stalled divider forces a timeout commit; reset mid-PENDING.
        tick(2);
        cmd(1'b0, 1'b0, 1'b1);
        wait_commit(c, 40);
        chk("t6_default_n", int'(n_out), 10);
        div_run = 1'b0;
        tick(2);
        cmd(1'b1, 1'b0, 1'b0);
        chk("t6_busy", int'(busy), 1);
        wait_commit(c, 40);
        chk("t6_timeout_cycles", c, 11);
        chk("t6_n_out", int'(n_out), 6);
        chk("t6_err", int'(timeout_err), 1);
        tick(5);
        chk("t6_err_sticky", int'(timeout_err), 1);
        cmd(1'b0, 1'b1, 1'b0);
        chk("t6_busy2", int'(busy), 1);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_rst_n", int'(n_out), 10);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_err", int'(timeout_err), 0);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
